// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rob_pkg
// Purpose  : Shared sizes, entry payload type and age helper for the ROB.
// Revision : 1.0 - initial release
// ============================================================================
package rob_pkg;

    localparam int ROB_WIDTH  = 5;
    localparam int PREG_WIDTH = 7;
    localparam int AREG_WIDTH = 5;
    localparam int N_CMPL     = 2;
    localparam int ROB_DEPTH  = 1 << ROB_WIDTH;

    typedef struct packed {
        logic                  has_dest;
        logic [AREG_WIDTH-1:0] areg;
        logic [PREG_WIDTH-1:0] preg;
        logic [PREG_WIDTH-1:0] old_preg;
    } rob_entry_t;

    // Distance from head, modulo ROB_DEPTH (natural wrap of the subtraction).
    function automatic logic [ROB_WIDTH-1:0] rob_age(input logic [ROB_WIDTH-1:0] tag,
                                                      input logic [ROB_WIDTH-1:0] head);
        return tag - head;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rob_commit_unit.sv
`default_nettype none
// ============================================================================
// Module   : rob_commit_unit
// Purpose  : Reorder buffer tracking dispatch, completion, in-order retire
//            and mispredict flush of younger entries.
// Revision : 1.0 - initial release
// ============================================================================
module rob_commit_unit
    import rob_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_alloc_valid,
    input  logic [ROB_WIDTH-1:0]         i_alloc_tag,
    input  logic                         i_alloc_has_dest,
    input  logic [AREG_WIDTH-1:0]        i_alloc_areg,
    input  logic [PREG_WIDTH-1:0]        i_alloc_preg,
    input  logic [PREG_WIDTH-1:0]        i_alloc_old_preg,
    input  logic [N_CMPL-1:0]            i_cmpl_valid,
    input  logic [N_CMPL*ROB_WIDTH-1:0]  i_cmpl_tag,
    input  logic                         i_branch_mispredict,
    input  logic [ROB_WIDTH-1:0]         i_flush_tag,
    output logic                         o_rob_full,
    output logic                         o_rob_empty,
    output logic                         o_retire_valid,
    output logic [ROB_WIDTH-1:0]         o_retire_tag,
    output logic                         o_retire_has_dest,
    output logic [AREG_WIDTH-1:0]        o_retire_areg,
    output logic [PREG_WIDTH-1:0]        o_retire_preg,
    output logic [PREG_WIDTH-1:0]        o_retire_old_preg,
    output logic                         o_err_tag_mismatch,
    output logic                         o_err_overflow
);

    localparam logic [ROB_WIDTH:0] C_DEPTH_CNT = (ROB_WIDTH+1)'(ROB_DEPTH);

    logic [ROB_DEPTH-1:0] r_valid;
    logic [ROB_DEPTH-1:0] r_done;
    rob_entry_t           r_entry [ROB_DEPTH];
    logic [ROB_WIDTH-1:0] r_head;
    logic [ROB_WIDTH-1:0] r_tail;
    logic [ROB_WIDTH:0]   r_count;

    logic                 r_retire_valid;
    logic [ROB_WIDTH-1:0] r_retire_tag;
    rob_entry_t           r_retire_entry;
    logic                 r_err_tag_mismatch;
    logic                 r_err_overflow;

    logic                 w_full;
    logic                 w_retire;
    logic                 w_alloc;
    logic [ROB_WIDTH-1:0] w_flush_age;
    logic [ROB_DEPTH-1:0] w_kill;
    logic [ROB_DEPTH-1:0] w_cmpl_set;
    logic [ROB_DEPTH-1:0] w_valid_nxt;
    logic [ROB_DEPTH-1:0] w_done_nxt;
    logic [ROB_WIDTH:0]   w_count_nxt;
    rob_entry_t           w_alloc_entry;

    assign w_full        = (r_count == C_DEPTH_CNT);
    assign w_retire      = r_valid[r_head] & r_done[r_head];
    assign w_alloc       = i_alloc_valid & ~w_full & ~i_branch_mispredict;
    assign w_flush_age   = rob_age(i_flush_tag, r_head);
    assign w_alloc_entry = '{has_dest: i_alloc_has_dest, areg: i_alloc_areg,
                             preg: i_alloc_preg, old_preg: i_alloc_old_preg};

    // Kill mask covers only entries strictly younger than the branch; the head
    // (age 0) can therefore still retire in the flush cycle.
    always_comb begin
        w_kill     = '0;
        w_cmpl_set = '0;
        for (int i = 0; i < ROB_DEPTH; i++) begin
            if (i_branch_mispredict && (rob_age(ROB_WIDTH'(i), r_head) > w_flush_age))
                w_kill[i] = 1'b1;
        end
        for (int p = 0; p < N_CMPL; p++) begin
            if (i_cmpl_valid[p])
                w_cmpl_set[i_cmpl_tag[p*ROB_WIDTH +: ROB_WIDTH]] = 1'b1;
        end
    end

    always_comb begin
        w_valid_nxt = r_valid & ~w_kill;
        w_done_nxt  = r_done | (w_cmpl_set & r_valid & ~w_kill);
        if (w_retire)
            w_valid_nxt[r_head] = 1'b0;
        if (w_alloc) begin
            w_valid_nxt[r_tail] = 1'b1;
            w_done_nxt[r_tail]  = 1'b0;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (i_branch_mispredict)
            w_count_nxt = (ROB_WIDTH+1)'(w_flush_age) + (ROB_WIDTH+1)'(1)
                        - (ROB_WIDTH+1)'(w_retire);
        else
            w_count_nxt = r_count + (ROB_WIDTH+1)'(w_alloc) - (ROB_WIDTH+1)'(w_retire);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid            <= '0;
            r_done             <= '0;
            r_head             <= '0;
            r_tail             <= '0;
            r_count            <= '0;
            r_retire_valid     <= 1'b0;
            r_retire_tag       <= '0;
            r_retire_entry     <= '0;
            r_err_tag_mismatch <= 1'b0;
            r_err_overflow     <= 1'b0;
        end else begin
            r_valid        <= w_valid_nxt;
            r_done         <= w_done_nxt;
            r_count        <= w_count_nxt;
            r_retire_valid <= w_retire;
            if (w_retire) begin
                r_head         <= r_head + 1'b1;
                r_retire_tag   <= r_head;
                r_retire_entry <= r_entry[r_head];
            end
            if (i_branch_mispredict)
                r_tail <= i_flush_tag + 1'b1;
            else if (w_alloc)
                r_tail <= r_tail + 1'b1;
            if (w_alloc && (i_alloc_tag != r_tail))
                r_err_tag_mismatch <= 1'b1;
            if (i_alloc_valid && w_full)
                r_err_overflow <= 1'b1;
        end
    end

    // Payload storage needs no reset: valid gates every use.
    always_ff @(posedge clk) begin
        if (w_alloc)
            r_entry[r_tail] <= w_alloc_entry;
    end

    assign o_rob_full         = w_full;
    assign o_rob_empty        = (r_count == '0);
    assign o_retire_valid     = r_retire_valid;
    assign o_retire_tag       = r_retire_tag;
    assign o_retire_has_dest  = r_retire_entry.has_dest;
    assign o_retire_areg      = r_retire_entry.areg;
    assign o_retire_preg      = r_retire_entry.preg;
    assign o_retire_old_preg  = r_retire_entry.old_preg;
    assign o_err_tag_mismatch = r_err_tag_mismatch;
    assign o_err_overflow     = r_err_overflow;

endmodule
`default_nettype wire

// File: tb/tb_rob_commit_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob_commit_unit
// Purpose  : Directed self-checking bench for rob_commit_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rob_commit_unit;
    import rob_pkg::*;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        alloc_valid;
    logic [ROB_WIDTH-1:0]        alloc_tag;
    logic                        alloc_has_dest;
    logic [AREG_WIDTH-1:0]       alloc_areg;
    logic [PREG_WIDTH-1:0]       alloc_preg;
    logic [PREG_WIDTH-1:0]       alloc_old_preg;
    logic [N_CMPL-1:0]           cmpl_valid;
    logic [N_CMPL*ROB_WIDTH-1:0] cmpl_tag;
    logic                        branch_mispredict;
    logic [ROB_WIDTH-1:0]        flush_tag;
    logic                        rob_full, rob_empty, retire_valid, retire_has_dest;
    logic [ROB_WIDTH-1:0]        retire_tag;
    logic [AREG_WIDTH-1:0]       retire_areg;
    logic [PREG_WIDTH-1:0]       retire_preg, retire_old_preg;
    logic                        err_tag_mismatch, err_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rob_commit_unit dut (
        .clk                (clk),
        .reset              (reset),
        .i_alloc_valid      (alloc_valid),
        .i_alloc_tag        (alloc_tag),
        .i_alloc_has_dest   (alloc_has_dest),
        .i_alloc_areg       (alloc_areg),
        .i_alloc_preg       (alloc_preg),
        .i_alloc_old_preg   (alloc_old_preg),
        .i_cmpl_valid       (cmpl_valid),
        .i_cmpl_tag         (cmpl_tag),
        .i_branch_mispredict(branch_mispredict),
        .i_flush_tag        (flush_tag),
        .o_rob_full         (rob_full),
        .o_rob_empty        (rob_empty),
        .o_retire_valid     (retire_valid),
        .o_retire_tag       (retire_tag),
        .o_retire_has_dest  (retire_has_dest),
        .o_retire_areg      (retire_areg),
        .o_retire_preg      (retire_preg),
        .o_retire_old_preg  (retire_old_preg),
        .o_err_tag_mismatch (err_tag_mismatch),
        .o_err_overflow     (err_overflow)
    );

    typedef struct {
        logic                 av;
        logic [ROB_WIDTH-1:0] atag;
        logic [1:0]           cv;
        logic [ROB_WIDTH-1:0] ct0;
        logic [ROB_WIDTH-1:0] ct1;
        logic                 erv;
        logic [ROB_WIDTH-1:0] ertag;
        logic                 eempty;
        logic                 efull;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Payload derived from a key so the bench knows what each retire must carry.
    function automatic rob_entry_t payload(input logic [4:0] key);
        rob_entry_t e;
        e.has_dest = key[0];
        e.areg     = key ^ 5'h15;
        e.preg     = {key, 2'b01};
        e.old_preg = {2'b10, key};
        return e;
    endfunction

    task automatic idle();
        alloc_valid       = 1'b0;
        alloc_tag         = '0;
        alloc_has_dest    = 1'b0;
        alloc_areg        = '0;
        alloc_preg        = '0;
        alloc_old_preg    = '0;
        cmpl_valid        = '0;
        cmpl_tag          = '0;
        branch_mispredict = 1'b0;
        flush_tag         = '0;
    endtask

    task automatic set_alloc(input logic [4:0] tag, input logic [4:0] key);
        rob_entry_t e;
        e              = payload(key);
        alloc_valid    = 1'b1;
        alloc_tag      = tag;
        alloc_has_dest = e.has_dest;
        alloc_areg     = e.areg;
        alloc_preg     = e.preg;
        alloc_old_preg = e.old_preg;
    endtask

    task automatic set_cmpl(input int p, input logic [4:0] tag);
        cmpl_valid[p]                      = 1'b1;
        cmpl_tag[p*ROB_WIDTH +: ROB_WIDTH] = tag;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_ret(input string name, input logic v, input logic [4:0] tag,
                           input logic [4:0] key);
        rob_entry_t e;
        e = payload(key);
        chk({name, "_rv"}, 32'(retire_valid), 32'(v));
        if (v) begin
            chk({name, "_tag"},  32'(retire_tag),      32'(tag));
            chk({name, "_hd"},   32'(retire_has_dest), 32'(e.has_dest));
            chk({name, "_areg"}, 32'(retire_areg),     32'(e.areg));
            chk({name, "_preg"}, 32'(retire_preg),     32'(e.preg));
            chk({name, "_old"},  32'(retire_old_preg), 32'(e.old_preg));
        end
    endtask

    task automatic do_reset(input string name);
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk({name, "_rv"},    32'(retire_valid),     32'(0));
        chk({name, "_tag"},   32'(retire_tag),       32'(0));
        chk({name, "_data"},  32'({retire_has_dest, retire_areg, retire_preg, retire_old_preg}), 32'(0));
        chk({name, "_empty"}, 32'(rob_empty),        32'(1));
        chk({name, "_full"},  32'(rob_full),         32'(0));
        chk({name, "_etag"},  32'(err_tag_mismatch), 32'(0));
        chk({name, "_eovf"},  32'(err_overflow),     32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 5'd1, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 5'd2, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 5'd0, 2'b01, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 5'd0, 2'b01, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 5'd0, 2'b01, 5'd1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd2, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0};

        idle();
        reset = 1'b1;
        step();

        // In-order retire with out-of-order completion
        do_reset("rst0");
        for (int i = 0; i < 9; i++) begin
            idle();
            if (tbl[i].av)    set_alloc(tbl[i].atag, tbl[i].atag);
            if (tbl[i].cv[0]) set_cmpl(0, tbl[i].ct0);
            if (tbl[i].cv[1]) set_cmpl(1, tbl[i].ct1);
            step();
            exp_ret($sformatf("t1v%0d", i), tbl[i].erv, tbl[i].ertag, tbl[i].ertag);
            chk($sformatf("t1v%0d_empty", i), 32'(rob_empty), 32'(tbl[i].eempty));
            chk($sformatf("t1v%0d_full", i),  32'(rob_full),  32'(tbl[i].efull));
        end
        chk("t1_tag_hold", 32'(retire_tag), 32'(2));

        // Fill, overflow, drain and wrap
        do_reset("rst1");
        for (int k = 0; k < 32; k++) begin
            idle();
            set_alloc(5'(k), 5'(k));
            step();
            if (k == 30) chk("t2_full_at31", 32'(rob_full), 32'(0));
        end
        chk("t2_full", 32'(rob_full), 32'(1));
        idle();
        set_alloc(5'd0, 5'd9);
        step();
        chk("t2_eovf", 32'(err_overflow), 32'(1));
        chk("t2_full_hold", 32'(rob_full), 32'(1));
        chk("t2_etag", 32'(err_tag_mismatch), 32'(0));
        for (int k = 0; k < 32; k++) begin
            idle();
            set_cmpl(0, 5'(k));
            step();
            if (k == 0) exp_ret("t2d0", 1'b0, 5'd0, 5'd0);
            else        exp_ret($sformatf("t2d%0d", k), 1'b1, 5'(k - 1), 5'(k - 1));
            if (k == 1) chk("t2_notfull", 32'(rob_full), 32'(0));
        end
        idle();
        step();
        exp_ret("t2d32", 1'b1, 5'd31, 5'd31);
        chk("t2_empty", 32'(rob_empty), 32'(1));
        idle();
        set_alloc(5'd0, 5'd3);
        step();
        chk("t2_wrap_etag", 32'(err_tag_mismatch), 32'(0));
        idle();
        set_cmpl(0, 5'd0);
        step();
        idle();
        step();
        exp_ret("t2_wrap", 1'b1, 5'd0, 5'd3);
        chk("t2_wrap_empty", 32'(rob_empty), 32'(1));

        // Flush at tag 3 with younger completions and a dropped alloc
        do_reset("rst2");
        for (int k = 0; k < 8; k++) begin
            idle();
            set_alloc(5'(k), 5'(k));
            step();
        end
        idle();
        set_cmpl(0, 5'd5);
        set_cmpl(1, 5'd6);
        step();
        idle();
        branch_mispredict = 1'b1;
        flush_tag         = 5'd3;
        set_alloc(5'd8, 5'd20);
        step();
        exp_ret("t3_flush", 1'b0, 5'd0, 5'd0);
        chk("t3_flush_empty", 32'(rob_empty), 32'(0));
        idle();
        set_alloc(5'd4, 5'd21);
        step();
        chk("t3_etag4", 32'(err_tag_mismatch), 32'(0));
        idle();
        set_alloc(5'd5, 5'd22);
        step();
        chk("t3_etag5", 32'(err_tag_mismatch), 32'(0));
        for (int k = 0; k < 4; k++) begin
            idle();
            set_cmpl(0, 5'(k));
            step();
            if (k > 0) exp_ret($sformatf("t3r%0d", k - 1), 1'b1, 5'(k - 1), 5'(k - 1));
        end
        idle();
        step();
        exp_ret("t3r3", 1'b1, 5'd3, 5'd3);
        idle();
        step();
        exp_ret("t3_stall4", 1'b0, 5'd0, 5'd0);
        idle();
        set_cmpl(0, 5'd4);
        step();
        exp_ret("t3_stall4b", 1'b0, 5'd0, 5'd0);
        idle();
        step();
        exp_ret("t3r4", 1'b1, 5'd4, 5'd21);
        idle();
        step();
        exp_ret("t3_stall5", 1'b0, 5'd0, 5'd0);
        chk("t3_notempty", 32'(rob_empty), 32'(0));
        idle();
        set_cmpl(0, 5'd5);
        step();
        idle();
        step();
        exp_ret("t3r5", 1'b1, 5'd5, 5'd22);
        chk("t3_empty", 32'(rob_empty), 32'(1));

        // Flush across the wrap point in the same cycle the head retires
        do_reset("rst3");
        for (int k = 0; k < 30; k++) begin
            idle();
            set_alloc(5'(k), 5'(k));
            step();
        end
        for (int k = 0; k < 30; k++) begin
            idle();
            set_cmpl(0, 5'(k));
            step();
        end
        idle();
        step();
        chk("t4_pre_empty", 32'(rob_empty), 32'(1));
        for (int k = 30; k < 34; k++) begin
            idle();
            set_alloc(5'(k), 5'(k));
            step();
        end
        idle();
        set_cmpl(0, 5'd30);
        step();
        idle();
        branch_mispredict = 1'b1;
        flush_tag         = 5'd31;
        set_cmpl(1, 5'd1);
        step();
        exp_ret("t4r30", 1'b1, 5'd30, 5'd30);
        chk("t4_notempty", 32'(rob_empty), 32'(0));
        idle();
        set_alloc(5'd0, 5'd12);
        step();
        chk("t4_etag", 32'(err_tag_mismatch), 32'(0));
        idle();
        set_cmpl(0, 5'd31);
        step();
        exp_ret("t4_wait31", 1'b0, 5'd0, 5'd0);
        idle();
        step();
        exp_ret("t4r31", 1'b1, 5'd31, 5'd31);
        idle();
        step();
        exp_ret("t4_stall0", 1'b0, 5'd0, 5'd0);
        chk("t4_live0", 32'(rob_empty), 32'(0));
        idle();
        set_cmpl(0, 5'd0);
        step();
        idle();
        step();
        exp_ret("t4r0", 1'b1, 5'd0, 5'd12);
        chk("t4_empty", 32'(rob_empty), 32'(1));

        // Tag mismatch writes at tail; reset mid-stream
        do_reset("rst4");
        idle(); set_alloc(5'd0, 5'd0); step();
        idle(); set_alloc(5'd1, 5'd1); step();
        idle(); set_alloc(5'd5, 5'd17); step();
        chk("t5_etag", 32'(err_tag_mismatch), 32'(1));
        idle();
        set_cmpl(0, 5'd0);
        set_cmpl(1, 5'd2);
        step();
        idle();
        set_cmpl(0, 5'd1);
        step();
        exp_ret("t5r0", 1'b1, 5'd0, 5'd0);
        idle();
        step();
        exp_ret("t5r1", 1'b1, 5'd1, 5'd1);
        idle();
        step();
        exp_ret("t5r2", 1'b1, 5'd2, 5'd17);
        idle(); set_alloc(5'd3, 5'd3); step();
        idle(); set_alloc(5'd4, 5'd4); step();
        do_reset("rst5");
        idle();
        set_alloc(5'd0, 5'd4);
        step();
        chk("t5_post_etag", 32'(err_tag_mismatch), 32'(0));
        chk("t5_post_empty", 32'(rob_empty), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
